rtc_alarm_clock: RTL and testbench
==================================

# rtc_alarm_clock

Parametrised real-time clock core with alarm. It keeps a 24-hour BCD time-of-day (HH:MM:SS) advanced by an internal 1-second prescaler and can present the time in 12-hour format. An alarm compare raises a timed, dismissable ring output. It sits between the board switch/key inputs and the BCD-to-7-segment display drivers, and replaces the fixed-width settable clock.

## Interface
- CLK_DIV, 50_000_000, Clock cycles per second; must be ≥ 2; prescaler width is $clog2(CLK_DIV)
- RING_SECS, 60, Seconds the alarm rings before self-cancelling; 1..255
- Clock  in  1  System clock; all state changes on its rising edge
- Reset  in  1  Asynchronous, active-high reset
- Load  in  1  Single-cycle pulse: load time from SetHr/SetMin, with seconds set to 00
- AlarmSet  in  1  Single-cycle pulse: store SetHr/SetMin as the alarm time
- SetHr  in  8  BCD hour, 24-hour format, 00..23
- SetMin  in  8  BCD minute, 00..59
- AlarmEn  in  1  Level: alarm armed
- Stop  in  1  Level/pulse: dismiss ringing
- Mode12  in  1  Level: 1 = 12-hour display, 0 = 24-hour display
- Hr  out  8  Displayed BCD hour (combinational from state and Mode12)
- Min, Sec  out  8 each  BCD minute and second
- PM  out  1  1 when internal hour ≥ 12; valid in both modes
- Tick  out  1  One-cycle pulse each second
- Ring  out  1  Alarm ringing
- Err  out  1  One-cycle pulse: Load/AlarmSet rejected

## Operation
- State: prescaler, 24-hour BCD time (six nibbles), alarm HH:MM (four nibbles), 8-bit ring counter, and a 2-state ring FSM (IDLE, RINGING).
- Prescaler: counts 0..CLK_DIV-1 and wraps. Tick = (count == CLK_DIV-1).
- Time advance on a Tick cycle:
  - sec_0 wraps 9→0 and carries into sec_1.
  - sec_1 wraps 5→0 and carries into min_0; minute digits carry the same way.
  - Hours: 09→10, 19→20, 23→00.
  - 23:59:59 → 00:00:00.
- Validation: a set value is valid iff each nibble ≤ 9, SetHr ≤ 0x23 and SetMin ≤ 0x59.
- Load with valid input:
  - time ← SetHr:SetMin:00 and prescaler ← 0.
  - Ring state is unaffected.
- AlarmSet with valid input: alarm ← SetHr:SetMin.
- Any invalid Load or AlarmSet: no state change, Err = 1 on the following cycle.
- Load and AlarmSet asserted together: both take effect; one Err pulse if the value is invalid.
- Display:
  - Mode12 = 0: Hr = internal hour.
  - Mode12 = 1: internal 00 → 12, 01..12 unchanged, 13..23 → hour − 12, in BCD (e.g. 0x17 → 0x05).
- Ring FSM:
  - IDLE → RINGING when Tick advances the time to exactly alarm HH:MM:00 and AlarmEn = 1 and Stop = 0. Ring counter ← RING_SECS − 1.
  - RINGING → IDLE on any of: Stop = 1; AlarmEn = 0; a Tick with ring counter = 0.
  - Otherwise, each Tick decrements the ring counter.
  - Ring = (state == RINGING).
- A Load onto the alarm time does not trigger the alarm; only a Tick-driven advance does.

## Timing
- Reset values: time 00:00:00, alarm 00:00, prescaler 0, state IDLE, Ring 0, Tick 0, Err 0, PM 0, Hr 0x00 (0x12 if Mode12 = 1).
- Reset is asynchronous and may arrive mid-ring or mid-count; all state returns to the reset values immediately.
- First Tick after reset (or after a valid Load) is at the CLK_DIV-th rising edge.
- Time registers update on the same edge on which Tick is high; Sec shows the new value one cycle after Tick.
- Ring rises on the same edge as the matching time update and stays high for RING_SECS Ticks, falling on the edge of the RING_SECS-th Tick.
- Stop or AlarmEn = 0 clears Ring on the next edge.
- Priority on one edge: Reset > Load > Tick advance. A Tick coinciding with a valid Load is discarded.
- For the ring FSM: Stop > trigger > countdown.
- Err is a registered one-cycle pulse; Hr/Min/Sec/PM have zero-cycle latency from Mode12.

## Test plan
- Rollover: CLK_DIV = 4; Load 23:59, wait 60 Ticks → time 00:00:00, PM 0; Tick period exactly 4 cycles.
- 12-hour mapping: Load 00:00, 12:00, 13:45, 23:00 with Mode12 = 1 → Hr 0x12/PM 0, 0x12/PM 1, 0x01/PM 1, 0x11/PM 1.
- Alarm ring:
  - CLK_DIV = 4, RING_SECS = 3; AlarmSet 07:01, Load 07:00, AlarmEn = 1.
  - Ring rises with the update to 07:01:00 and falls after 3 Ticks at 07:01:03.
  - Repeat with Stop pulsed mid-ring → Ring falls on the next edge.
- No false trigger: AlarmSet 08:00, Load 08:00 with AlarmEn = 1 → Ring stays 0 through the minute. Trigger with Stop held high → no ring.
- Invalid set: Load SetHr 0x24, then SetMin 0x5A, then AlarmSet SetHr 0x1F → Err pulses three times; time and alarm unchanged.
- Load vs Tick and async reset:
  - Valid Load on a Tick cycle → time = set value with Sec 00; next Tick after CLK_DIV cycles.
  - Reset asserted mid-cycle while ringing → all outputs at reset values before the next edge.

Source files
------------

// File: rtl/rtc_alarm_clock.sv
// Real-time clock core with alarm.
// Keeps a 24-hour BCD time of day advanced by a 1-second prescaler, shows it
// in 24- or 12-hour format, and rings a timed, dismissable alarm.
module rtc_alarm_clock #(
  parameter int CLK_DIV   = 50_000_000,
  parameter int RING_SECS = 60
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic       AlarmSet,
  input  logic [7:0] SetHr,
  input  logic [7:0] SetMin,
  input  logic       AlarmEn,
  input  logic       Stop,
  input  logic       Mode12,
  output logic [7:0] Hr,
  output logic [7:0] Min,
  output logic [7:0] Sec,
  output logic       PM,
  output logic       Tick,
  output logic       Ring,
  output logic       Err
);

  localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [7:0]    RING_INIT = 8'(RING_SECS - 1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RINGING = 1'b1
  } ring_state_t;

  // A set value is accepted only if every nibble is a decimal digit and
  // the hour/minute are inside a day.
  function automatic logic set_valid(input logic [7:0] hr, input logic [7:0] mn);
    set_valid = (hr[7:4] <= 4'd9) && (hr[3:0] <= 4'd9) &&
                (mn[7:4] <= 4'd9) && (mn[3:0] <= 4'd9) &&
                (hr <= 8'h23) && (mn <= 8'h59);
  endfunction

  // Map a 24-hour BCD hour onto the 12-hour dial (00 -> 12, 13..23 -> 01..11).
  function automatic logic [7:0] hr_to_12(input logic [7:0] hr);
    logic [4:0] bin_v;
    logic [4:0] adj_v;
    bin_v = (5'(hr[7:4]) * 5'd10) + 5'(hr[3:0]);
    adj_v = bin_v - 5'd12;
    if (bin_v == 5'd0) begin
      hr_to_12 = 8'h12;
    end else if (bin_v <= 5'd12) begin
      hr_to_12 = hr;
    end else if (adj_v >= 5'd10) begin
      hr_to_12 = {4'd1, 4'(adj_v - 5'd10)};
    end else begin
      hr_to_12 = {4'd0, adj_v[3:0]};
    end
  endfunction

  logic [PW-1:0] presc_r;
  logic [7:0]    sec_r;
  logic [7:0]    min_r;
  logic [7:0]    hr_r;
  logic [7:0]    alm_hr_r;
  logic [7:0]    alm_min_r;
  logic [7:0]    ring_cnt_r;
  logic          err_r;
  ring_state_t   state_r;
  ring_state_t   state_nxt_s;

  logic          set_ok_s;
  logic          load_ok_s;
  logic          alm_ok_s;
  logic          tick_s;
  logic          adv_s;
  logic          trig_s;
  logic          ring_s;
  logic [7:0]    nxt_sec_s;
  logic [7:0]    nxt_min_s;
  logic [7:0]    nxt_hr_s;

  // Qualify set requests and the one-second strobe; a Load wins over a Tick.
  always_comb begin
    set_ok_s  = set_valid(SetHr, SetMin);
    load_ok_s = Load && set_ok_s;
    alm_ok_s  = AlarmSet && set_ok_s;
    tick_s    = (presc_r == PRESC_MAX);
    adv_s     = tick_s && !load_ok_s;
  end

  // BCD time of day one second ahead of the current value, with all carries.
  always_comb begin
    nxt_sec_s = sec_r;
    nxt_min_s = min_r;
    nxt_hr_s  = hr_r;
    if (sec_r[3:0] != 4'd9) begin
      nxt_sec_s = {sec_r[7:4], sec_r[3:0] + 4'd1};
    end else if (sec_r[7:4] != 4'd5) begin
      nxt_sec_s = {sec_r[7:4] + 4'd1, 4'd0};
    end else begin
      nxt_sec_s = 8'h00;
      if (min_r[3:0] != 4'd9) begin
        nxt_min_s = {min_r[7:4], min_r[3:0] + 4'd1};
      end else if (min_r[7:4] != 4'd5) begin
        nxt_min_s = {min_r[7:4] + 4'd1, 4'd0};
      end else begin
        nxt_min_s = 8'h00;
        if (hr_r == 8'h23) begin
          nxt_hr_s = 8'h00;
        end else if (hr_r[3:0] == 4'd9) begin
          nxt_hr_s = {hr_r[7:4] + 4'd1, 4'd0};
        end else begin
          nxt_hr_s = {hr_r[7:4], hr_r[3:0] + 4'd1};
        end
      end
    end
  end

  // Alarm fires only when a real one-second advance lands on HH:MM:00.
  always_comb begin
    trig_s = adv_s && AlarmEn && !Stop &&
             (nxt_sec_s == 8'h00) &&
             (nxt_min_s == alm_min_r) &&
             (nxt_hr_s == alm_hr_r);
  end

  // One-second prescaler; restarts on a valid Load so the next Tick is a full second away.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      presc_r <= '0;
    end else if (load_ok_s || tick_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Time-of-day registers: Load has priority over the Tick advance.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hr_r  <= 8'h00;
      min_r <= 8'h00;
      sec_r <= 8'h00;
    end else if (load_ok_s) begin
      hr_r  <= SetHr;
      min_r <= SetMin;
      sec_r <= 8'h00;
    end else if (tick_s) begin
      hr_r  <= nxt_hr_s;
      min_r <= nxt_min_s;
      sec_r <= nxt_sec_s;
    end else begin
      hr_r  <= hr_r;
      min_r <= min_r;
      sec_r <= sec_r;
    end
  end

  // Stored alarm time.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      alm_hr_r  <= 8'h00;
      alm_min_r <= 8'h00;
    end else if (alm_ok_s) begin
      alm_hr_r  <= SetHr;
      alm_min_r <= SetMin;
    end else begin
      alm_hr_r  <= alm_hr_r;
      alm_min_r <= alm_min_r;
    end
  end

  // One-cycle error pulse for any rejected Load/AlarmSet (one pulse even if both).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (Load || AlarmSet) && !set_ok_s;
    end
  end

  // Ring FSM state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Ring FSM next state: dismissal beats trigger beats countdown.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (trig_s) begin
          state_nxt_s = RINGING;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RINGING: begin
        if (Stop || !AlarmEn) begin
          state_nxt_s = IDLE;
        end else if (adv_s && (ring_cnt_r == 8'd0)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RINGING;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Remaining ring seconds: loaded on trigger, decremented on each advance while ringing.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ring_cnt_r <= 8'd0;
    end else if ((state_r == IDLE) && trig_s) begin
      ring_cnt_r <= RING_INIT;
    end else if ((state_r == RINGING) && adv_s && (ring_cnt_r != 8'd0)) begin
      ring_cnt_r <= ring_cnt_r - 8'd1;
    end else begin
      ring_cnt_r <= ring_cnt_r;
    end
  end

  // Ring FSM outputs.
  always_comb begin
    ring_s = (state_r == RINGING);
  end

  // Display outputs follow state and Mode12 with no added latency.
  always_comb begin
    if (Mode12) begin
      Hr = hr_to_12(hr_r);
    end else begin
      Hr = hr_r;
    end
    Min  = min_r;
    Sec  = sec_r;
    PM   = (hr_r >= 8'h12);
    Tick = tick_s;
    Ring = ring_s;
    Err  = err_r;
  end

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Self-checking bench for rtc_alarm_clock: directed scenarios plus random
// traffic, compared every cycle against a seconds-of-day reference model.
module tb_rtc_alarm_clock;

  localparam int CLK_DIV   = 4;
  localparam int RING_SECS = 3;

  logic       Clock;
  logic       Reset;
  logic       Load;
  logic       AlarmSet;
  logic [7:0] SetHr;
  logic [7:0] SetMin;
  logic       AlarmEn;
  logic       Stop;
  logic       Mode12;
  logic [7:0] Hr;
  logic [7:0] Min;
  logic [7:0] Sec;
  logic       PM;
  logic       Tick;
  logic       Ring;
  logic       Err;

  int n_checks;
  int n_errors;

  // Reference model state (plain integers).
  int m_tod;
  int m_presc;
  int m_alarm;
  int m_left;
  bit m_ring;
  bit m_err;

  bit cur_en;
  bit cur_m12;

  rtc_alarm_clock #(.CLK_DIV(CLK_DIV), .RING_SECS(RING_SECS)) dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .AlarmSet(AlarmSet),
    .SetHr(SetHr), .SetMin(SetMin), .AlarmEn(AlarmEn), .Stop(Stop),
    .Mode12(Mode12), .Hr(Hr), .Min(Min), .Sec(Sec), .PM(PM),
    .Tick(Tick), .Ring(Ring), .Err(Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_tod   = 0;
    m_presc = 0;
    m_alarm = 0;
    m_left  = 0;
    m_ring  = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock edge of the reference behaviour, from the current inputs.
  task automatic model_step();
    int hv;
    int mv;
    bit ok;
    bit tick;
    bit adv;
    bit trig;
    hv = int'(SetHr[7:4]) * 10 + int'(SetHr[3:0]);
    mv = int'(SetMin[7:4]) * 10 + int'(SetMin[3:0]);
    ok = (SetHr[7:4] <= 4'd9) && (SetHr[3:0] <= 4'd9) &&
         (SetMin[7:4] <= 4'd9) && (SetMin[3:0] <= 4'd9) && (hv < 24) && (mv < 60);
    tick  = (m_presc == CLK_DIV - 1);
    m_err = (Load || AlarmSet) && !ok;
    adv   = 1'b0;
    if (Load && ok) begin
      m_tod   = hv * 3600 + mv * 60;
      m_presc = 0;
    end else begin
      m_presc = (m_presc + 1) % CLK_DIV;
      if (tick) begin
        adv   = 1'b1;
        m_tod = (m_tod + 1) % 86400;
      end
    end
    trig = adv && AlarmEn && !Stop && (m_tod == m_alarm * 60);
    if (AlarmSet && ok) m_alarm = hv * 60 + mv;
    if (m_ring) begin
      if (Stop || !AlarmEn) m_ring = 1'b0;
      else if (adv) begin
        if (m_left == 0) m_ring = 1'b0;
        else m_left--;
      end
    end else if (trig) begin
      m_ring = 1'b1;
      m_left = RING_SECS - 1;
    end
  endtask

  task automatic check_all();
    int h;
    int dh;
    h  = m_tod / 3600;
    dh = Mode12 ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
    check_val("sec",  Sec,  to_bcd(m_tod % 60));
    check_val("min",  Min,  to_bcd((m_tod / 60) % 60));
    check_val("hr",   Hr,   to_bcd(dh));
    check_val("pm",   PM,   (h >= 12));
    check_val("tick", Tick, (m_presc == CLK_DIV - 1));
    check_val("ring", Ring, m_ring);
    check_val("err",  Err,  m_err);
  endtask

  // Drive inputs at a falling edge, step model on the rising edge, check at next falling edge.
  task automatic cycle(input bit ld, input bit al, input logic [7:0] sh, input logic [7:0] sm,
                       input bit en, input bit stp, input bit m12);
    Load = ld; AlarmSet = al; SetHr = sh; SetMin = sm;
    AlarmEn = en; Stop = stp; Mode12 = m12;
    cur_en = en; cur_m12 = m12;
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, cur_en, 1'b0, cur_m12);
  endtask

  initial begin
    int r;
    int am;
    n_checks = 0;
    n_errors = 0;
    cur_en = 1'b0;
    cur_m12 = 1'b0;
    Reset = 1'b1; Load = 1'b0; AlarmSet = 1'b0; SetHr = 8'h00; SetMin = 8'h00;
    AlarmEn = 1'b0; Stop = 1'b0; Mode12 = 1'b0;
    model_reset();
    repeat (3) @(negedge Clock);
    check_all();
    Mode12 = 1'b1;
    #1 check_all();
    Mode12 = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;

    // Midnight rollover.
    cycle(1'b1, 1'b0, 8'h23, 8'h59, 1'b0, 1'b0, 1'b0);
    idle(60 * CLK_DIV);
    check_val("rollover_hms", {8'h00, Hr, Min, Sec}, 32'h0);

    // 12-hour display mapping.
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("h12_0000", {PM, Hr}, {1'b0, 8'h12});
    cycle(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("h12_1200", {PM, Hr}, {1'b1, 8'h12});
    cycle(1'b1, 1'b0, 8'h13, 8'h45, 1'b0, 1'b0, 1'b1);
    check_val("h12_1345", {PM, Hr}, {1'b1, 8'h01});
    cycle(1'b1, 1'b0, 8'h23, 8'h00, 1'b0, 1'b0, 1'b1);
    check_val("h12_2300", {PM, Hr}, {1'b1, 8'h11});

    // Alarm rings for RING_SECS seconds.
    cycle(1'b0, 1'b1, 8'h07, 8'h01, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(60 * CLK_DIV);
    check_val("ring_rise", {Ring, Hr, Min, Sec}, {1'b1, 24'h070100});
    idle(70 * CLK_DIV);

    // Stop pulsed mid-ring.
    cycle(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(60 * CLK_DIV + 4);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    check_val("stop_clears", Ring, 1'b0);
    idle(20);

    // No trigger from a Load onto the alarm time, nor while Stop is held.
    cycle(1'b1, 1'b1, 8'h08, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(70 * CLK_DIV);
    cycle(1'b1, 1'b0, 8'h07, 8'h59, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 70 * CLK_DIV; i++) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

    // Invalid set values.
    cycle(1'b1, 1'b0, 8'h24, 8'h00, 1'b1, 1'b0, 1'b0);
    check_val("err_hr24", Err, 1'b1);
    idle(1);
    cycle(1'b1, 1'b0, 8'h12, 8'h5A, 1'b1, 1'b0, 1'b0);
    idle(1);
    cycle(1'b0, 1'b1, 8'h1F, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1);
    cycle(1'b1, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Valid Load on a Tick cycle.
    for (int k = 0; (k < 2 * CLK_DIV) && (m_presc != CLK_DIV - 1); k++) idle(1);
    check_val("tick_before_load", Tick, 1'b1);
    cycle(1'b1, 1'b0, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    idle(2 * CLK_DIV + 1);

    // Asynchronous reset while ringing.
    cycle(1'b0, 1'b1, 8'h07, 8'h01, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; (k < 70 * CLK_DIV) && !m_ring; k++) idle(1);
    check_val("ringing_before_reset", Ring, 1'b1);
    #2 Reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge Clock);
    check_all();
    Reset = 1'b0;

    // Random traffic; alarms mostly aimed at the next minute so rings occur.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom % 1000;
      if (($urandom % 100) == 0) cur_m12 = !cur_m12;
      if (r < 5) begin
        if (($urandom % 4) == 0)
          cycle(1'b1, 1'b0, 8'($urandom), 8'($urandom), ($urandom % 20) != 0, 1'b0, cur_m12);
        else
          cycle(1'b1, 1'b0, to_bcd($urandom % 24), to_bcd($urandom % 60), 1'b1, 1'b0, cur_m12);
      end else if (r < 15) begin
        am = (m_tod / 60 + 1) % 1440;
        if (($urandom % 4) == 0)
          cycle(1'b0, 1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0, cur_m12);
        else
          cycle(1'b0, 1'b1, to_bcd(am / 60), to_bcd(am % 60), 1'b1, 1'b0, cur_m12);
      end else begin
        cycle(1'b0, 1'b0, 8'h00, 8'h00, ($urandom % 200) != 0, ($urandom % 300) == 0, cur_m12);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
